// File: rtl/shot_resolver_pkg.sv
// Shared battleship definitions: board geometry, hit-count limits, resolver
// FSM encoding, shooter encoding and small index/counter helpers.
package shot_resolver_pkg;

    localparam int GRID       = 8;
    localparam int COORD_W    = 3;
    localparam int SHIP_CELLS = 17;
    localparam int HIT_W      = 5;
    localparam int CELLS      = GRID * GRID;
    localparam int IDX_W      = 2 * COORD_W;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOOKUP   = 2'd1,
        ST_REPORT   = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_e;

    typedef enum logic {
        SHOOTER_P1 = 1'b0,
        SHOOTER_P2 = 1'b1
    } shooter_e;

    function automatic logic [IDX_W-1:0] cell_idx(input logic [COORD_W-1:0] row,
                                                  input logic [COORD_W-1:0] col);
        return IDX_W'(row) * IDX_W'(GRID) + IDX_W'(col);
    endfunction

    function automatic logic coord_ok(input logic [COORD_W-1:0] coord);
        return ({1'b0, coord} < (COORD_W + 1)'(GRID));
    endfunction

    function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] value);
        return (value == {HIT_W{1'b1}}) ? value : value + HIT_W'(1);
    endfunction

endpackage

// File: rtl/shot_resolver_shot_map.sv
// Per-player shot history: one bit per board cell, set once fired upon,
// cleared synchronously, with a combinational test port.
module shot_map
    import shot_resolver_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic [IDX_W-1:0] test_idx,
    output logic             test_bit,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             set_en
);

    logic [CELLS-1:0] bits_r;

    // History register: clear wins over set.
    always_ff @(posedge clk) begin
        if (clear) begin
            bits_r <= {CELLS{1'b0}};
        end else if (set_en) begin
            bits_r[set_idx] <= 1'b1;
        end
    end

    assign test_bit = bits_r[test_idx];

endmodule

// File: rtl/shot_resolver.sv
// Resolves a permitted shot against the opponent's ship map: tracks shot
// history and hit counts, reports hit/miss/repeat and latches the winner.
module shot_resolver
    import shot_resolver_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 p1fire,
    input  logic                 p2fire,
    input  logic                 fire_valid,
    input  logic [COORD_W-1:0]   target_row,
    input  logic [COORD_W-1:0]   target_col,
    input  logic [CELLS-1:0]     p1_ships,
    input  logic [CELLS-1:0]     p2_ships,
    output logic                 busy,
    output logic                 result_valid,
    output logic                 hit,
    output logic                 repeat_shot,
    output logic                 shooter,
    output logic                 turn_done,
    output logic                 protocol_err,
    output logic [HIT_W-1:0]     p1_hits,
    output logic [HIT_W-1:0]     p2_hits,
    output logic                 game_over,
    output logic                 winner
);

    state_e            state_r, state_next_s;
    shooter_e          shooter_r;
    logic [IDX_W-1:0]  idx_r;
    logic [HIT_W-1:0]  p1_hits_r, p2_hits_r;
    logic              busy_r, result_valid_r, hit_r, repeat_r, shooter_out_r;
    logic              turn_done_r, protocol_err_r, game_over_r, winner_r;

    logic              req_ok_s, accept_s, reject_s, lookup_s, win_s;
    logic              p1_seen_s, p2_seen_s, own_seen_s, opp_ship_s, new_hit_s;
    logic              p1_set_s, p2_set_s;
    logic [HIT_W-1:0]  shooter_hits_s;

    shot_map u_p1_map (
        .clk      (clk),
        .clear    (reset),
        .test_idx (idx_r),
        .test_bit (p1_seen_s),
        .set_idx  (idx_r),
        .set_en   (p1_set_s)
    );

    shot_map u_p2_map (
        .clk      (clk),
        .clear    (reset),
        .test_idx (idx_r),
        .test_bit (p2_seen_s),
        .set_idx  (idx_r),
        .set_en   (p2_set_s)
    );

    // Lookup datapath: history of the latched shooter, opponent's ship bit.
    always_comb begin
        req_ok_s       = fire_valid & (p1fire ^ p2fire) & coord_ok(target_row) & coord_ok(target_col);
        lookup_s       = (state_r == ST_LOOKUP);
        own_seen_s     = 1'b0;
        opp_ship_s     = 1'b0;
        shooter_hits_s = {HIT_W{1'b0}};
        if (shooter_r == SHOOTER_P2) begin
            own_seen_s     = p2_seen_s;
            opp_ship_s     = p1_ships[idx_r];
            shooter_hits_s = p2_hits_r;
        end else begin
            own_seen_s     = p1_seen_s;
            opp_ship_s     = p2_ships[idx_r];
            shooter_hits_s = p1_hits_r;
        end
        new_hit_s = ~own_seen_s & opp_ship_s;
        p1_set_s  = lookup_s & ~own_seen_s & (shooter_r == SHOOTER_P1);
        p2_set_s  = lookup_s & ~own_seen_s & (shooter_r == SHOOTER_P2);
    end

    // Next-state logic; fire_valid outside IDLE/GAMEOVER is dropped silently.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        reject_s     = 1'b0;
        win_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_ok_s) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_LOOKUP;
                end else begin
                    reject_s     = fire_valid;
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                state_next_s = ST_REPORT;
            end
            ST_REPORT: begin
                if (shooter_hits_s == HIT_W'(SHIP_CELLS)) begin
                    win_s        = 1'b1;
                    state_next_s = ST_GAMEOVER;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_GAMEOVER: begin
                reject_s     = fire_valid;
                state_next_s = ST_GAMEOVER;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, latched request, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            shooter_r      <= SHOOTER_P1;
            idx_r          <= {IDX_W{1'b0}};
            p1_hits_r      <= {HIT_W{1'b0}};
            p2_hits_r      <= {HIT_W{1'b0}};
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
            hit_r          <= 1'b0;
            repeat_r       <= 1'b0;
            shooter_out_r  <= 1'b0;
            turn_done_r    <= 1'b0;
            protocol_err_r <= 1'b0;
            game_over_r    <= 1'b0;
            winner_r       <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            busy_r         <= (state_next_s != ST_IDLE);
            protocol_err_r <= reject_s;
            result_valid_r <= lookup_s;
            turn_done_r    <= lookup_s & ~own_seen_s;
            if (accept_s) begin
                shooter_r <= p2fire ? SHOOTER_P2 : SHOOTER_P1;
                idx_r     <= cell_idx(target_row, target_col);
            end
            if (lookup_s) begin
                hit_r         <= new_hit_s;
                repeat_r      <= own_seen_s;
                shooter_out_r <= shooter_r;
            end
            if (lookup_s && new_hit_s && shooter_r == SHOOTER_P1) begin
                p1_hits_r <= sat_inc(p1_hits_r);
            end
            if (lookup_s && new_hit_s && shooter_r == SHOOTER_P2) begin
                p2_hits_r <= sat_inc(p2_hits_r);
            end
            if (win_s) begin
                game_over_r <= 1'b1;
                winner_r    <= shooter_r;
            end
        end
    end

    assign busy         = busy_r;
    assign result_valid = result_valid_r;
    assign hit          = hit_r;
    assign repeat_shot  = repeat_r;
    assign shooter      = shooter_out_r;
    assign turn_done    = turn_done_r;
    assign protocol_err = protocol_err_r;
    assign p1_hits      = p1_hits_r;
    assign p2_hits      = p2_hits_r;
    assign game_over    = game_over_r;
    assign winner       = winner_r;

endmodule

// File: doc/shot_resolver.md
Name: shot_resolver

Overview:
- Resolves a player's shot against the opponent's ship map once turn control has granted fire permission (p1fire/p2fire).
- Sits downstream of the turn/fire-permission logic and upstream of the score/display logic.
- Records every shot, reports hit/miss/repeat, and counts hits per player.
- Returns a turn_done pulse so turn control can hand over, and latches the winner.

Parameters:
- GRID, 8, board edge length in cells.
- COORD_W, 3, width of row/column coordinates.
- SHIP_CELLS, 17, total ship cells per board; reaching this hit count wins.
- HIT_W, 5, width of the per-player hit counters.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- p1fire  input  1  player 1 holds fire permission.
- p2fire  input  1  player 2 holds fire permission.
- fire_valid  input  1  one-cycle strobe: target coordinate is valid.
- target_row  input  COORD_W  target row.
- target_col  input  COORD_W  target column.
- p1_ships  input  GRID*GRID  player 1 ship map; bit index = row*GRID+col; static during play.
- p2_ships  input  GRID*GRID  player 2 ship map.
- busy  output  1  high while not in IDLE.
- result_valid  output  1  one-cycle result strobe.
- hit  output  1  result is a hit; valid with result_valid.
- repeat_shot  output  1  cell already fired on by this shooter; valid with result_valid.
- shooter  output  1  0 = player 1, 1 = player 2; valid with result_valid.
- turn_done  output  1  one-cycle pulse: a new (non-repeat) shot has resolved.
- protocol_err  output  1  one-cycle pulse: fire_valid was rejected.
- p1_hits  output  HIT_W  player 1 hit count.
- p2_hits  output  HIT_W  player 2 hit count.
- game_over  output  1  a player has won.
- winner  output  1  0 = player 1, 1 = player 2; valid while game_over.

Behaviour:
- Reset: all outputs 0; both shot-history maps (GRID*GRID bits each) cleared; hit counters 0; FSM in IDLE. Reset in any state aborts the operation in progress with no result emitted.
- FSM states: IDLE, LOOKUP, REPORT, GAMEOVER.
- IDLE, accept: fire_valid with exactly one of p1fire/p2fire high. Latch the shooter and idx = target_row*GRID+target_col, then go to LOOKUP.
- IDLE, reject: fire_valid with both or neither permission high, or target_row/target_col >= GRID. Pulse protocol_err the next cycle and stay in IDLE.
- LOOKUP, repeat: if the shooter's history bit at idx is set, set repeat_shot=1 and hit=0. No map or counter change.
- LOOKUP, new shot: set the history bit and hit = opponent ship bit at idx. If hit, increment the shooter's counter (saturating at 2^HIT_W-1).
- LOOKUP always goes to REPORT.
- REPORT: result_valid=1 for exactly one cycle.
- REPORT, turn_done: pulses together with result_valid only for non-repeat shots. On a repeat the same player keeps the turn.
- REPORT, exit: if the shooter's counter == SHIP_CELLS, set game_over=1 and winner=shooter, then go to GAMEOVER; otherwise go to IDLE.
- Latency: fire_valid accepted in cycle N gives result_valid in cycle N+2. busy is high in cycles N+1 and N+2.
- fire_valid while busy is ignored; no protocol_err and no queuing.
- GAMEOVER: absorbing until reset. Every fire_valid pulses protocol_err; counters and maps are frozen.
- hit, repeat_shot and shooter hold their values until the next result; turn_done, result_valid and protocol_err are single-cycle pulses.
- Index arithmetic is unsigned at width 2*COORD_W.

Decomposition:
- Shared battleship package holds: GRID, COORD_W, SHIP_CELLS, HIT_W, the FSM state encoding, and the shooter encoding (P1=0, P2=1).
- One natural sub-module, shot_map: a GRID*GRID-bit history register with synchronous clear, a test port (idx -> bit), and a set port (idx, en). Instantiate it once per player.

Test Plan:
- Single hit: reset; p1fire=1, p2_ships bit 10 set, fire at row1/col2 -> two cycles later result_valid=1, hit=1, shooter=0, turn_done=1, p1_hits=1.
- Miss, then repeat: p2fire=1, fire at (0,0) on an empty cell -> hit=0, turn_done=1. Fire (0,0) again -> repeat_shot=1, turn_done=0, p2_hits unchanged.
- Rejected requests: fire_valid with p1fire=p2fire=1, then with both 0 -> protocol_err pulses once per request, no result_valid, maps unchanged.
- Win: p1 hits all 17 ship cells of p2_ships -> game_over=1, winner=0, p1_hits=17. A further fire_valid gives protocol_err and no result.
- Reset mid-operation: assert reset in the LOOKUP cycle -> no result_valid. Re-firing the same cell afterwards is a new shot (repeat_shot=0).
- Busy drop: a second fire_valid during REPORT -> ignored, and exactly one result is produced.
